// File: rtl/roi_crop_pkg.sv
// Shared definitions for the ROI crop / light-dark statistics block:
// frame-tracking state encoding and default parameter values.
package roi_crop_pkg;

   typedef enum logic [1:0] {
      SYNC    = 2'd0,
      ACTIVE  = 2'd1,
      PUBLISH = 2'd2
   } roiState_t;

   localparam int DEF_DATA_W   = 10;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_COORD_W  = 16;
   localparam int DEF_CNT_W    = 20;

endpackage

// File: rtl/roi_xy_counter.sv
// Raster position tracker: X/Y of the pixel being accepted this cycle,
// with line wrap, last-pixel flag and restart to (0,0) on start of frame.
module roi_xy_counter
   import roi_crop_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int COORD_W  = DEF_COORD_W
)(
   input  logic               iCLK,
   input  logic               iRST,
   input  logic               iStep,
   input  logic               iRestart,
   output logic [COORD_W-1:0] oX,
   output logic [COORD_W-1:0] oY,
   output logic               oAtOrigin,
   output logic               oLast
);

   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

   logic [COORD_W-1:0] xReg;
   logic [COORD_W-1:0] yReg;

   // Position of the current pixel: a start-of-frame pixel is always (0,0).
   assign oX        = iRestart ? '0 : xReg;
   assign oY        = iRestart ? '0 : yReg;
   assign oAtOrigin = (xReg == '0) && (yReg == '0);
   assign oLast     = (oX == X_LAST) && (oY == Y_LAST);

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         xReg <= '0;
         yReg <= '0;
      end else if (iStep) begin
         if (oLast) begin
            xReg <= '0;
            yReg <= '0;
         end else if (oX == X_LAST) begin
            xReg <= '0;
            yReg <= oY + 1'b1;
         end else begin
            xReg <= oX + 1'b1;
            yReg <= oY;
         end
      end
   end

endmodule

// File: rtl/roi_crop_stats.sv
// Region-of-interest crop (blank or gate) with per-frame light/dark pixel
// statistics, published once per completed frame.
module roi_crop_stats
   import roi_crop_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int COORD_W  = DEF_COORD_W,
   parameter int CNT_W    = DEF_CNT_W
)(
   input  logic               iCLK,
   input  logic               iRST,
   input  logic               iDVAL,
   input  logic               iSOF,
   input  logic [DATA_W-1:0]  iDATA,
   input  logic [COORD_W-1:0] iXSTART,
   input  logic [COORD_W-1:0] iXEND,
   input  logic [COORD_W-1:0] iYSTART,
   input  logic [COORD_W-1:0] iYEND,
   input  logic [DATA_W-1:0]  iTHRESH,
   input  logic               iMODE,
   output logic               oDVAL,
   output logic [DATA_W-1:0]  oDATA,
   output logic [CNT_W-1:0]   oLIGHT_CNT,
   output logic [CNT_W-1:0]   oDARK_CNT,
   output logic               oSTAT_VALID,
   output logic               oFRAME_ERR
);

   roiState_t          state;
   logic [COORD_W-1:0] xStartSh, xEndSh, yStartSh, yEndSh;
   logic [DATA_W-1:0]  threshSh;
   logic               modeSh;
   logic [CNT_W-1:0]   lightAcc, darkAcc;

   logic [COORD_W-1:0] pixX, pixY;
   logic               atOrigin, lastPix;
   logic               sofPix, accept, frameErr, inWin, isLight;
   logic [COORD_W-1:0] xs, xe, ys, ye;
   logic [DATA_W-1:0]  th;
   logic               md;
   logic [CNT_W-1:0]   lightBase, darkBase;

   assign sofPix   = iDVAL & iSOF;
   assign accept   = sofPix | (iDVAL & (state == ACTIVE));
   assign frameErr = sofPix & (state == ACTIVE) & ~atOrigin;

   // The start-of-frame pixel already obeys the window it loads.
   assign xs = sofPix ? iXSTART : xStartSh;
   assign xe = sofPix ? iXEND   : xEndSh;
   assign ys = sofPix ? iYSTART : yStartSh;
   assign ye = sofPix ? iYEND   : yEndSh;
   assign th = sofPix ? iTHRESH : threshSh;
   assign md = sofPix ? iMODE   : modeSh;

   assign inWin   = (pixX >= xs) && (pixX <= xe) && (pixY >= ys) && (pixY <= ye);
   assign isLight = iDATA > th;

   // Accumulators restart from zero for any pixel that opens a frame.
   assign lightBase = ((state == ACTIVE) && !frameErr) ? lightAcc : '0;
   assign darkBase  = ((state == ACTIVE) && !frameErr) ? darkAcc  : '0;

   roi_xy_counter #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .COORD_W  (COORD_W)
   ) uXy (
      .iCLK      (iCLK),
      .iRST      (iRST),
      .iStep     (accept),
      .iRestart  (sofPix),
      .oX        (pixX),
      .oY        (pixY),
      .oAtOrigin (atOrigin),
      .oLast     (lastPix)
   );

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state       <= SYNC;
         xStartSh    <= '0;
         xEndSh      <= '0;
         yStartSh    <= '0;
         yEndSh      <= '0;
         threshSh    <= '0;
         modeSh      <= 1'b0;
         lightAcc    <= '0;
         darkAcc     <= '0;
         oDVAL       <= 1'b0;
         oDATA       <= '0;
         oLIGHT_CNT  <= '0;
         oDARK_CNT   <= '0;
         oSTAT_VALID <= 1'b0;
         oFRAME_ERR  <= 1'b0;
      end else begin
         oSTAT_VALID <= (state == PUBLISH);
         oFRAME_ERR  <= frameErr;
         if (state == PUBLISH) begin
            oLIGHT_CNT <= lightAcc;
            oDARK_CNT  <= darkAcc;
         end

         if (sofPix) begin
            xStartSh <= iXSTART;
            xEndSh   <= iXEND;
            yStartSh <= iYSTART;
            yEndSh   <= iYEND;
            threshSh <= iTHRESH;
            modeSh   <= iMODE;
         end

         oDVAL <= accept & (inWin | ~md);
         if (accept && inWin) begin
            oDATA <= iDATA;
         end else if (accept && !md) begin
            oDATA <= '0;
         end

         lightAcc <= lightBase;
         darkAcc  <= darkBase;
         if (accept && inWin) begin
            if (isLight) begin
               lightAcc <= (lightBase == '1) ? lightBase : lightBase + 1'b1;
            end else begin
               darkAcc  <= (darkBase == '1) ? darkBase : darkBase + 1'b1;
            end
         end

         if (accept && lastPix) begin
            state <= PUBLISH;
         end else if (accept) begin
            state <= ACTIVE;
         end else if (state == PUBLISH) begin
            state <= SYNC;
         end
      end
   end

endmodule

// File: tb/tb_roi_crop_stats.sv
// Bench for roi_crop_stats on an 8x4 raster: directed scenarios plus random
// frames, all checked against a pixel-index reference model.
module tb_roi_crop_stats;

   localparam int DW = 10;
   localparam int H  = 8;
   localparam int V  = 4;
   localparam int CW = 16;
   localparam int NW = 8;
   localparam int NPIX = H * V;

   logic          iCLK = 1'b0;
   logic          iRST;
   logic          iDVAL, iSOF, iMODE;
   logic [DW-1:0] iDATA, iTHRESH;
   logic [CW-1:0] iXSTART, iXEND, iYSTART, iYEND;
   logic          oDVAL, oSTAT_VALID, oFRAME_ERR;
   logic [DW-1:0] oDATA;
   logic [NW-1:0] oLIGHT_CNT, oDARK_CNT;

   always #5 iCLK = ~iCLK;

   roi_crop_stats #(
      .DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(CW), .CNT_W(NW)
   ) dut (
      .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iSOF(iSOF), .iDATA(iDATA),
      .iXSTART(iXSTART), .iXEND(iXEND), .iYSTART(iYSTART), .iYEND(iYEND),
      .iTHRESH(iTHRESH), .iMODE(iMODE), .oDVAL(oDVAL), .oDATA(oDATA),
      .oLIGHT_CNT(oLIGHT_CNT), .oDARK_CNT(oDARK_CNT),
      .oSTAT_VALID(oSTAT_VALID), .oFRAME_ERR(oFRAME_ERR)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: frame progress expressed as a raster index.
   bit mOn, mPend;
   int mIdx, mLight, mDark, mPubL, mPubD;
   int sXs, sXe, sYs, sYe, sTh;
   bit sMode;
   bit eDval, eStat, eErr;
   int eData;

   // Observations gathered for scenario-level checks.
   int obsDval, obsStat, obsErr;
   int obsData[$];

   task automatic model_reset();
      mOn = 0; mPend = 0; mIdx = 0; mLight = 0; mDark = 0; mPubL = 0; mPubD = 0;
      sXs = 0; sXe = 0; sYs = 0; sYe = 0; sTh = 0; sMode = 0;
      eDval = 0; eStat = 0; eErr = 0; eData = 0;
   endtask

   task automatic obs_clear();
      obsDval = 0; obsStat = 0; obsErr = 0;
      obsData.delete();
   endtask

   task automatic model_step(input bit dv, input bit sof, input int d);
      int x, y;
      bit inw;
      eStat = mPend;
      eErr  = 0;
      eDval = 0;
      if (mPend) begin
         mPubL = mLight; mPubD = mDark;
         mLight = 0; mDark = 0; mPend = 0; mOn = 0;
      end
      if (dv && sof) begin
         if (mOn && mIdx != 0) eErr = 1;
         mOn = 1; mIdx = 0; mLight = 0; mDark = 0;
         sXs = int'(iXSTART); sXe = int'(iXEND);
         sYs = int'(iYSTART); sYe = int'(iYEND);
         sTh = int'(iTHRESH); sMode = iMODE;
      end
      if (dv && mOn) begin
         x = mIdx % H;
         y = mIdx / H;
         inw = (x >= sXs) && (x <= sXe) && (y >= sYs) && (y <= sYe);
         if (inw) begin
            eDval = 1; eData = d;
            if (d > sTh) mLight = (mLight < 255) ? mLight + 1 : 255;
            else         mDark  = (mDark  < 255) ? mDark  + 1 : 255;
         end else if (!sMode) begin
            eDval = 1; eData = 0;
         end
         mIdx++;
         if (mIdx == NPIX) begin
            mOn = 0; mPend = 1; mIdx = 0;
         end
      end
   endtask

   // One clock of stimulus; the output stream is compared every cycle.
   task automatic cyc(input bit dv, input bit sof, input int d);
      logic [DW-1:0] ed;
      iDVAL = dv; iSOF = sof; iDATA = DW'(d);
      @(posedge iCLK);
      #1;
      model_step(dv, sof, d);
      ed = DW'(eData);
      vectors += 6;
      if (oDVAL !== eDval) begin
         miscompares++; $display("FAIL oDVAL: got %0b expected %0b", oDVAL, eDval);
      end
      if (oDATA !== ed) begin
         miscompares++; $display("FAIL oDATA: got %0d expected %0d", oDATA, ed);
      end
      if (oSTAT_VALID !== eStat) begin
         miscompares++; $display("FAIL oSTAT_VALID: got %0b expected %0b", oSTAT_VALID, eStat);
      end
      if (oFRAME_ERR !== eErr) begin
         miscompares++; $display("FAIL oFRAME_ERR: got %0b expected %0b", oFRAME_ERR, eErr);
      end
      if (oLIGHT_CNT !== NW'(mPubL)) begin
         miscompares++; $display("FAIL oLIGHT_CNT: got %0d expected %0d", oLIGHT_CNT, mPubL);
      end
      if (oDARK_CNT !== NW'(mPubD)) begin
         miscompares++; $display("FAIL oDARK_CNT: got %0d expected %0d", oDARK_CNT, mPubD);
      end
      if (oDVAL === 1'b1) begin
         obsDval++; obsData.push_back(int'(oDATA));
      end
      if (oSTAT_VALID === 1'b1) begin
         obsStat++;
         $display("frame published: light=%0d dark=%0d", oLIGHT_CNT, oDARK_CNT);
      end
      if (oFRAME_ERR === 1'b1) obsErr++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, $urandom_range(1), $urandom_range(1023));
   endtask

   task automatic set_cfg(input int xs, input int xe, input int ys, input int ye,
                          input int th, input bit md);
      iXSTART = CW'(xs); iXEND = CW'(xe); iYSTART = CW'(ys); iYEND = CW'(ye);
      iTHRESH = DW'(th); iMODE = md;
   endtask

   // dmode: 0 -> X+1, 1 -> X, 2 -> random.
   task automatic frame_part(input int first, input int last, input int dmode,
                             input int gapPct, input bit sofEn);
      int d;
      for (int i = first; i < last; i++) begin
         while ($urandom_range(99) < gapPct) idle(1);
         d = (dmode == 0) ? (i % H) + 1 : (dmode == 1) ? (i % H) : $urandom_range(1023);
         cyc(1, sofEn && (i == 0), d);
      end
   endtask

   task automatic apply_reset();
      @(negedge iCLK);
      iRST = 1'b0; iDVAL = 1'b0; iSOF = 1'b0;
      #1;
      model_reset();
      vectors += 4;
      if (oDVAL !== 1'b0 || oDATA !== '0) begin
         miscompares++; $display("FAIL reset_pixel: got dval=%0b data=%0d expected 0/0", oDVAL, oDATA);
      end
      if (oLIGHT_CNT !== '0 || oDARK_CNT !== '0) begin
         miscompares++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", oLIGHT_CNT, oDARK_CNT);
      end
      if (oSTAT_VALID !== 1'b0) begin
         miscompares++; $display("FAIL reset_stat: got %0b expected 0", oSTAT_VALID);
      end
      if (oFRAME_ERR !== 1'b0) begin
         miscompares++; $display("FAIL reset_err: got %0b expected 0", oFRAME_ERR);
      end
      repeat (2) @(negedge iCLK);
      iRST = 1'b1;
   endtask

   task automatic test_reset();
      iRST = 1'b1; iDVAL = 0; iSOF = 0; iDATA = '0;
      set_cfg(0, 0, 0, 0, 0, 0);
      #2;
      apply_reset();
      obs_clear();
      idle(3);
   endtask

   task automatic test_blank();
      obs_clear();
      set_cfg(2, 5, 1, 2, 0, 0);
      frame_part(0, NPIX, 0, 0, 1);
      vectors++;
      if (obsStat != 0) begin
         miscompares++; $display("FAIL blank_stat_early: got %0d pulses expected 0", obsStat);
      end
      idle(1);
      vectors += 4;
      if (oSTAT_VALID !== 1'b1) begin
         miscompares++; $display("FAIL blank_stat_timing: got %0b expected 1", oSTAT_VALID);
      end
      if (oLIGHT_CNT !== 8'd8 || oDARK_CNT !== 8'd0) begin
         miscompares++; $display("FAIL blank_counts: got %0d/%0d expected 8/0", oLIGHT_CNT, oDARK_CNT);
      end
      if (obsDval != NPIX) begin
         miscompares++; $display("FAIL blank_dval_count: got %0d expected %0d", obsDval, NPIX);
      end
      begin
         int nz = 0;
         foreach (obsData[i]) if (obsData[i] != 0) nz++;
         if (nz != 8) begin
            miscompares++; $display("FAIL blank_nonzero: got %0d expected 8", nz);
         end
      end
      idle(3);
      vectors++;
      if (obsStat != 1) begin
         miscompares++; $display("FAIL blank_stat_count: got %0d expected 1", obsStat);
      end
   endtask

   task automatic test_gate();
      obs_clear();
      set_cfg(2, 5, 1, 2, 0, 1);
      frame_part(0, NPIX, 0, 0, 1);
      idle(3);
      vectors++;
      if (obsDval != 8) begin
         miscompares++; $display("FAIL gate_dval_count: got %0d expected 8", obsDval);
      end
      for (int i = 0; i < obsDval && i < 8; i++) begin
         vectors++;
         if (obsData[i] != 3 + (i % 4)) begin
            miscompares++; $display("FAIL gate_data[%0d]: got %0d expected %0d", i, obsData[i], 3 + (i % 4));
         end
      end
   endtask

   task automatic test_thresh();
      obs_clear();
      set_cfg(0, 7, 0, 3, 4, 0);
      frame_part(0, NPIX, 1, 20, 1);
      idle(3);
      vectors += 2;
      if (oLIGHT_CNT !== 8'd12 || oDARK_CNT !== 8'd20) begin
         miscompares++; $display("FAIL thresh_counts: got %0d/%0d expected 12/20", oLIGHT_CNT, oDARK_CNT);
      end
      if (obsStat != 1) begin
         miscompares++; $display("FAIL thresh_stat_count: got %0d expected 1", obsStat);
      end
   endtask

   task automatic test_frame_err();
      obs_clear();
      set_cfg(0, 7, 0, 3, 4, 0);
      frame_part(0, 13, 1, 0, 1);
      frame_part(0, NPIX, 1, 0, 1);
      idle(3);
      vectors += 3;
      if (obsErr != 1) begin
         miscompares++; $display("FAIL err_pulses: got %0d expected 1", obsErr);
      end
      if (obsStat != 1) begin
         miscompares++; $display("FAIL err_stat_count: got %0d expected 1", obsStat);
      end
      if (oLIGHT_CNT !== 8'd12 || oDARK_CNT !== 8'd20) begin
         miscompares++; $display("FAIL err_counts: got %0d/%0d expected 12/20", oLIGHT_CNT, oDARK_CNT);
      end
   endtask

   task automatic test_mid_change();
      obs_clear();
      set_cfg(2, 5, 1, 2, 0, 0);
      frame_part(0, 16, 0, 0, 1);
      set_cfg(0, 7, 0, 3, 0, 0);
      frame_part(16, NPIX, 0, 0, 1);
      idle(2);
      vectors++;
      if (oLIGHT_CNT !== 8'd8 || oDARK_CNT !== 8'd0) begin
         miscompares++; $display("FAIL change_cur_frame: got %0d/%0d expected 8/0", oLIGHT_CNT, oDARK_CNT);
      end
      frame_part(0, NPIX, 0, 0, 1);
      idle(2);
      vectors++;
      if (oLIGHT_CNT !== 8'd32 || oDARK_CNT !== 8'd0) begin
         miscompares++; $display("FAIL change_next_frame: got %0d/%0d expected 32/0", oLIGHT_CNT, oDARK_CNT);
      end
   endtask

   task automatic test_back_to_back();
      obs_clear();
      set_cfg(1, 6, 0, 3, $urandom_range(1023), 0);
      frame_part(0, NPIX, 2, 0, 1);
      frame_part(0, NPIX, 2, 0, 1);
      idle(3);
      vectors++;
      if (obsStat != 2) begin
         miscompares++; $display("FAIL b2b_stat_count: got %0d expected 2", obsStat);
      end
   endtask

   task automatic test_reset_midframe();
      set_cfg(0, 7, 0, 3, 4, 0);
      frame_part(0, 10, 1, 0, 1);
      apply_reset();
      obs_clear();
      frame_part(0, NPIX, 1, 0, 0);
      idle(3);
      vectors += 2;
      if (obsDval != 0) begin
         miscompares++; $display("FAIL nosof_dval: got %0d expected 0", obsDval);
      end
      if (obsStat != 0 || oLIGHT_CNT !== '0 || oDARK_CNT !== '0) begin
         miscompares++; $display("FAIL nosof_counts: got stat=%0d %0d/%0d expected 0 0/0",
                                 obsStat, oLIGHT_CNT, oDARK_CNT);
      end
      frame_part(0, NPIX, 1, 10, 1);
      idle(3);
      vectors++;
      if (obsStat != 1 || oLIGHT_CNT !== 8'd12 || oDARK_CNT !== 8'd20) begin
         miscompares++; $display("FAIL postreset_frame: got stat=%0d %0d/%0d expected 1 12/20",
                                 obsStat, oLIGHT_CNT, oDARK_CNT);
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 24; f++) begin
         set_cfg($urandom_range(9), $urandom_range(9), $urandom_range(5), $urandom_range(5),
                 $urandom_range(1023), $urandom_range(1));
         if ($urandom_range(3) == 0) frame_part(0, $urandom_range(1, NPIX - 1), 2, 25, 1);
         else                        frame_part(0, NPIX, 2, 25, 1);
         if ($urandom_range(1) == 1) idle($urandom_range(4));
      end
      idle(4);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_blank();
      test_gate();
      test_thresh();
      test_frame_err();
      test_mid_change();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
